// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants, types and the register-enable legality helper.
package cpu_pkg;

    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // True for an all-zero (idle) or single-hot enable pattern.
    function automatic logic onehot_ok(input logic [NUM_REGS-1:0] v);
        return (v & (v - 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/reg_onehot_check.sv
// Classifies the decoder's register-enable bus into idle / legal / illegal
// and encodes the selected register index.
module reg_onehot_check
    import cpu_pkg::*;
(
    input  logic [NUM_REGS-1:0] reg_en,
    output logic                is_idle,
    output logic                is_legal,
    output logic                is_illegal,
    output reg_addr_t           enc_idx
);

    // is_legal covers idle too; a real write is is_legal && !is_idle.
    assign is_idle    = (reg_en == '0);
    assign is_legal   = onehot_ok(reg_en);
    assign is_illegal = !is_legal;

    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_en[i]) enc_idx = reg_addr_t'(i);
        end
    end

endmodule

// File: rtl/reg_file_8x.sv
// Eight-entry register file fed by a one-hot enable bus, with two registered
// read ports, optional write bypass, sticky multi-hot error and write counter.
module reg_file_8x
    import cpu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REGS-1:0] reg_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  reg_addr_t           rd_sel_a,
    input  reg_addr_t           rd_sel_b,
    output logic [WIDTH-1:0]    rd_data_a,
    output logic [WIDTH-1:0]    rd_data_b,
    input  logic                err_clr,
    output logic                onehot_err,
    output logic [7:0]          wr_count
);

    logic [WIDTH-1:0] regs [NUM_REGS];

    logic      is_idle;
    logic      is_legal;
    logic      is_illegal;
    reg_addr_t enc_idx;

    reg_onehot_check u_check (
        .reg_en    (reg_en),
        .is_idle   (is_idle),
        .is_legal  (is_legal),
        .is_illegal(is_illegal),
        .enc_idx   (enc_idx)
    );

    logic wr_accept;
    logic wr_store;
    logic [WIDTH-1:0] rd_next_a;
    logic [WIDTH-1:0] rd_next_b;

    // A write to r0 under ZERO_R0 is accepted (counted) but never stored.
    assign wr_accept = is_legal && !is_idle;
    assign wr_store  = wr_accept && !((ZERO_R0 != 0) && (enc_idx == '0));

    function automatic logic [WIDTH-1:0] read_val(input reg_addr_t sel);
        logic [WIDTH-1:0] v;
        v = regs[sel];
        if ((BYPASS != 0) && wr_accept && (enc_idx == sel))
            v = wr_data;
        if ((ZERO_R0 != 0) && (sel == '0))
            v = '0;
        return v;
    endfunction

    assign rd_next_a = read_val(rd_sel_a);
    assign rd_next_b = read_val(rd_sel_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_store) begin
            regs[enc_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_data_a <= rd_next_a;
            rd_data_b <= rd_next_b;
        end
    end

    // Set beats clear when both occur on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             onehot_err <= 1'b0;
        else if (is_illegal) onehot_err <= 1'b1;
        else if (err_clr)    onehot_err <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 wr_count <= '0;
        else if (wr_accept && wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
    end

endmodule

// File: tb/tb_reg_file_8x.sv
// Directed self-checking bench for reg_file_8x; a second instance with
// BYPASS=0 shares all inputs to cover the non-bypass read timing.
module tb_reg_file_8x;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  reg_en = '0;
    logic [15:0] wr_data = '0;
    logic [2:0]  rd_sel_a = '0;
    logic [2:0]  rd_sel_b = '0;
    logic        err_clr = 1'b0;
    logic [15:0] rd_data_a, rd_data_b, nb_data_a, nb_data_b;
    logic        onehot_err, nb_err;
    logic [7:0]  wr_count, nb_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    reg_file_8x #(.WIDTH(16), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .reg_en(reg_en), .wr_data(wr_data),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .err_clr(err_clr), .onehot_err(onehot_err), .wr_count(wr_count)
    );

    reg_file_8x #(.WIDTH(16), .ZERO_R0(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .reg_en(reg_en), .wr_data(wr_data),
        .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b),
        .rd_data_a(nb_data_a), .rd_data_b(nb_data_b),
        .err_clr(err_clr), .onehot_err(nb_err), .wr_count(nb_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [15:0] d);
        reg_en  = 8'(1 << idx);
        wr_data = d;
        tick();
        reg_en  = '0;
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    endtask

    logic [15:0] exp_reg [8];

    initial begin
        rst = 1'b1;
        #12;
        rst = 1'b0;
        tick();
        chk("rst_a", 32'(rd_data_a), 32'h0);
        chk("rst_cnt", 32'(wr_count), 32'h0);

        // reset mid-cycle after reg3 holds data
        wr(3, 16'h1234);
        rd_sel_a = 3'd3; rd_sel_b = 3'd3;
        tick();
        chk("pre_rst_a", 32'(rd_data_a), 32'h1234);
        chk("pre_rst_cnt", 32'(wr_count), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_imm_a", 32'(rd_data_a), 32'h0);
        chk("rst_imm_b", 32'(rd_data_b), 32'h0);
        chk("rst_imm_err", 32'(onehot_err), 32'h0);
        chk("rst_imm_cnt", 32'(wr_count), 32'h0);
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        tick();
        chk("post_rst_r3", 32'(rd_data_a), 32'h0);

        // write every register, then read all on both ports
        for (int i = 0; i < 8; i++) begin
            wr(i, 16'hA000 + 16'(i));
            exp_reg[i] = (i == 0) ? 16'h0 : 16'hA000 + 16'(i);
        end
        chk("cnt_8", 32'(wr_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            rd_sel_a = 3'(i);
            rd_sel_b = 3'(7 - i);
            tick();
            chk($sformatf("rd_a_%0d", i), 32'(rd_data_a), 32'(exp_reg[i]));
            chk($sformatf("rd_b_%0d", 7 - i), 32'(rd_data_b), 32'(exp_reg[7 - i]));
        end

        // same-cycle bypass on reg5
        wr(5, 16'h0001);
        rd_sel_a = 3'd5; rd_sel_b = 3'd5;
        wr(5, 16'hBEEF);
        chk("byp_a", 32'(rd_data_a), 32'hBEEF);
        chk("byp_b", 32'(rd_data_b), 32'hBEEF);
        chk("nobyp_a_old", 32'(nb_data_a), 32'h0001);
        chk("nobyp_b_old", 32'(nb_data_b), 32'h0001);
        tick();
        chk("nobyp_a_new", 32'(nb_data_a), 32'hBEEF);
        chk("nobyp_b_new", 32'(nb_data_b), 32'hBEEF);

        // bypass must not leak a write into r0
        rd_sel_a = 3'd0;
        wr(0, 16'h1111);
        chk("byp_r0", 32'(rd_data_a), 32'h0);
        chk("cnt_r0", 32'(wr_count), 32'(exp_cnt));

        // illegal multi-hot enable
        rd_sel_a = 3'd2; rd_sel_b = 3'd4;
        reg_en = 8'b0001_0100; wr_data = 16'hDEAD;
        tick();
        reg_en = '0;
        chk("ill_err", 32'(onehot_err), 32'h1);
        chk("ill_err_nb", 32'(nb_err), 32'h1);
        chk("ill_cnt", 32'(wr_count), 32'(exp_cnt));
        tick();
        tick();
        chk("ill_r2", 32'(rd_data_a), 32'hA002);
        chk("ill_r4", 32'(rd_data_b), 32'hA004);
        chk("ill_hold", 32'(onehot_err), 32'h1);

        // set wins over clear, then clear alone
        err_clr = 1'b1; reg_en = 8'hFF;
        tick();
        chk("clr_vs_set", 32'(onehot_err), 32'h1);
        reg_en = '0;
        tick();
        err_clr = 1'b0;
        chk("clr", 32'(onehot_err), 32'h0);
        chk("clr_cnt", 32'(wr_count), 32'(exp_cnt));

        // saturation
        for (int i = 0; i < 300; i++) wr(1, 16'(i));
        chk("sat_cnt", 32'(wr_count), 32'hFF);
        wr(1, 16'd299);
        chk("sat_hold", 32'(wr_count), 32'hFF);
        chk("sat_nb", 32'(nb_count), 32'hFF);
        rd_sel_a = 3'd1;
        tick();
        chk("sat_r1", 32'(rd_data_a), 32'd299);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_file_8x.md
Name: reg_file_8x

Overview:
- Eight-entry general-purpose register file. It is the receiving end of the one-hot register-enable bus produced by the register-select decoder.
- It consumes the 8-bit one-hot write enable plus write data, and provides two independently addressed read ports with registered outputs.
- It detects illegal (multi-hot) enable patterns and flags them with a sticky error.
- Sits in the CPU datapath between the writeback stage (decoder + result mux) and operand fetch.

Parameters:
- WIDTH, 16, data width of each register and of all data ports.
- ZERO_R0, 1, when 1 register 0 is hardwired to zero and writes to it are discarded; when 0, register 0 is an ordinary register.
- BYPASS, 1, when 1 a read of a register written in the same cycle returns the new data; when 0 it returns the old contents.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- reg_en  input  8  one-hot write enable from the register-select decoder; bit i writes register i; all-zero means no register write (RAM cycle)
- wr_data  input  WIDTH  write data, sampled on a rising clk when reg_en is non-zero
- rd_sel_a  input  3  read address, port A
- rd_sel_b  input  3  read address, port B
- rd_data_a  output  WIDTH  registered read data, port A
- rd_data_b  output  WIDTH  registered read data, port B
- err_clr  input  1  synchronous clear of onehot_err
- onehot_err  output  1  sticky flag: a multi-hot reg_en was seen
- wr_count  output  8  saturating count of accepted register writes (debug)

Behaviour:
- Reset (async, rst=1): all 8 registers, rd_data_a, rd_data_b, onehot_err and wr_count go to 0 immediately. While rst is high, no writes are accepted.
- Write classification, each rising clk, from reg_en:
  - all-zero: idle; no state change.
  - exactly one bit i set: register i <= wr_data. If ZERO_R0=1 and i=0, the write is discarded but still counted as accepted.
  - two or more bits set: no register is written; onehot_err <= 1.
- Read, each rising clk: rd_data_x <= reg[rd_sel_x]. Latency is 1 cycle from address to data.
- BYPASS=1: if the same edge accepts a legal write to register rd_sel_x, rd_data_x <= wr_data, except that register 0 with ZERO_R0=1 always reads 0.
- BYPASS=0: rd_data_x gets the pre-write contents; the new value is visible one cycle later.
- Ports A and B are fully independent. Both may address the same register and must return identical data.
- onehot_err:
  - Set by a multi-hot cycle; cleared by err_clr=1.
  - If err_clr and a multi-hot cycle coincide, set wins: onehot_err = 1.
  - An illegal write never corrupts any register.
- wr_count increments by 1 per legal single-hot write and saturates at 8'hFF; it does not wrap.
- rd_data outputs change only on clk edges or reset. No combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_pkg holds:
  - constant NUM_REGS = 8
  - constant REG_ADDR_W = 3
  - typedef reg_addr_t (3-bit)
  - a function onehot_ok(8-bit) returning 1 for zero or single-hot.
- One natural sub-module, reg_onehot_check: combinational classifier of reg_en, with outputs is_idle, is_legal, is_illegal, and enc_idx[2:0].
- Storage and read muxes stay in reg_file_8x.

Test Plan:
- Reset: assert rst mid-cycle after writing reg3=16'h1234 → rd_data_a/b, onehot_err and wr_count read 0 immediately; after release, reading reg3 returns 16'h0000.
- Write/read every register: for each i, write reg_en=1<<i with wr_data=16'hA000+i, then read all eight on both ports → reg0=0 (ZERO_R0=1), reg i=16'hA000+i, each valid 1 cycle after the address; wr_count=8.
- Same-cycle bypass: reg5=16'h0001; on one edge write reg5=16'hBEEF with rd_sel_a=rd_sel_b=5 → both read 16'hBEEF next cycle (BYPASS=1); with BYPASS=0 they read 16'h0001, then 16'hBEEF one cycle later.
- Illegal enable: reg_en=8'b0001_0100 with wr_data=16'hDEAD → reg2 and reg4 unchanged, onehot_err=1, wr_count unchanged; the flag holds through idle cycles.
- Clear versus set priority: err_clr=1 together with reg_en=8'hFF → onehot_err stays 1; err_clr=1 with reg_en=0 on the next cycle → onehot_err=0.
- Saturation: perform 300 legal writes to reg1 → wr_count=8'hFF and stays there; reg1 holds the last wr_data.
